ram_arbiter: RTL

Shares one simple-dual-port block RAM (one write port, one read port, shared clock) between two read requesters and two write requesters. It arbitrates each port independently, drives the RAM's address, data and enable pins, and tracks the RAM's fixed read latency. Read data comes back to the requester that issued it, marked with a per-requester valid strobe. It sits between game-logic/renderer clients and the RAM instance, so no client ever drives the RAM directly.

---
 rtl/ram_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one simple-dual-port block RAM between two readers and two writers.
// The read and write ports are arbitrated independently. Grants are combinational. The
// return path follows the RAM's fixed read latency through a valid/id pipeline.
// Optional feature: define RAM_ARB_RR_EN for round-robin arbitration on each port.
// When it is undefined, requester 0 has fixed priority over requester 1.
module ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clka,
    input  logic              rst_n,
    // read requesters
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_valid,
    output logic              r1_valid,
    output logic [DATA_W-1:0] r0_data,
    output logic [DATA_W-1:0] r1_data,
    // write requesters
    input  logic              w0_req,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic              w1_req,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    output logic              w0_gnt,
    output logic              w1_gnt,
    // RAM pins
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic              ram_enb,
    output logic              ram_regceb,
    output logic              ram_rstb,
    input  logic [DATA_W-1:0] ram_doutb
);

    // Only a RAM without an output register (1) or with one (2) is supported.
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("ram_arbiter: RD_LAT must be 1 or 2");
    end

    // Which requester wins a contested cycle on each port (0 or 1).
    logic rd_pref;
    logic wr_pref;

`ifdef RAM_ARB_RR_EN
    logic rd_ptr_q;
    logic rd_ptr_d;
    logic wr_ptr_q;
    logic wr_ptr_d;

    // After any grant, hand priority to the requester that did not win.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (r0_gnt || r1_gnt) begin
            rd_ptr_d = r0_gnt;
        end
        if (w0_gnt || w1_gnt) begin
            wr_ptr_d = w0_gnt;
        end
    end

    // Round-robin pointer registers; reset prefers requester 0.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign rd_pref = rd_ptr_q;
    assign wr_pref = wr_ptr_q;
`else
    assign rd_pref = 1'b0;
    assign wr_pref = 1'b0;
`endif

    // Read-port arbiter: single requester wins outright, contention resolved by rd_pref.
    always_comb begin
        r0_gnt = 1'b0;
        r1_gnt = 1'b0;
        if (rst_n) begin
            if (r0_req && r1_req) begin
                r0_gnt = ~rd_pref;
                r1_gnt = rd_pref;
            end else begin
                r0_gnt = r0_req;
                r1_gnt = r1_req;
            end
        end
    end

    // Write-port arbiter: same policy, independent of the read port.
    always_comb begin
        w0_gnt = 1'b0;
        w1_gnt = 1'b0;
        if (rst_n) begin
            if (w0_req && w1_req) begin
                w0_gnt = ~wr_pref;
                w1_gnt = wr_pref;
            end else begin
                w0_gnt = w0_req;
                w1_gnt = w1_req;
            end
        end
    end

    // RAM pin muxes. All pins are held at zero while reset is asserted.
    always_comb begin
        ram_addrb = '0;
        ram_enb   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        ram_wea   = 1'b0;
        if (rst_n) begin
            ram_addrb = r1_gnt ? r1_addr : r0_addr;
            ram_enb   = r0_gnt | r1_gnt;
            ram_addra = w1_gnt ? w1_addr : w0_addr;
            ram_dina  = w1_gnt ? w1_data : w0_data;
            ram_wea   = w0_gnt | w1_gnt;
        end
    end

    // In-flight read tracking: stage 0 takes this cycle's grant, later stages shift.
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [RD_LAT-1:0] pipe_vld_d;
    logic [RD_LAT-1:0] pipe_id_q;
    logic [RD_LAT-1:0] pipe_id_d;

    // Next-state of the valid/id pipeline.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_id_d     = pipe_id_q;
        pipe_vld_d[0] = r0_gnt | r1_gnt;
        pipe_id_d[0]  = r1_gnt;
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_id_d[k]  = pipe_id_q[k-1];
        end
    end

    // Pipeline registers; reset drops every in-flight read.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    // Return path: RAM data is broadcast, the last stage picks the owner.
    assign r0_valid = pipe_vld_q[RD_LAT-1] & ~pipe_id_q[RD_LAT-1];
    assign r1_valid = pipe_vld_q[RD_LAT-1] &  pipe_id_q[RD_LAT-1];
    assign r0_data  = ram_doutb;
    assign r1_data  = ram_doutb;
    assign ram_rstb = ~rst_n;

    // The output register only exists on the two-cycle RAM; it loads one cycle after the read.
    if (RD_LAT == 2) begin : g_regce
        assign ram_regceb = pipe_vld_q[0];
    end else begin : g_no_regce
        assign ram_regceb = 1'b0;
    end

endmodule
